imm_encode: RTL

//  Inverse of the immediate extender: takes a 32-bit value and an ImmSrc class
//  and produces the 24-bit instruction immediate field that the extender would

---
 rtl/imm_encode_if.sv | 45 ++++
 rtl/imm_encode.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encode_if.sv
// -----------------------------------------------------------------------------
// imm_encode_if
//   Request/response bundle for the immediate encoder.
//
//   Start    requester -> encoder  request, sampled only when the encoder is idle
//                                  or presenting a result
//   ImmSrc   requester -> encoder  immediate class: 00=DP, 01=MEM, 10=B, 11=invalid
//   Value    requester -> encoder  32-bit value to encode
//   Busy     encoder -> requester  computation in progress, Start ignored
//   Done     encoder -> requester  one-cycle pulse, Valid/EncData just updated
//   Valid    encoder -> requester  Value was encodable for the requested class
//   EncData  encoder -> requester  24-bit instruction immediate field
//
//   master: the side that issues requests (instruction builder, testbench)
//   slave : the encoder itself
// -----------------------------------------------------------------------------
interface imm_encode_if;
  logic        Start;
  logic [1:0]  ImmSrc;
  logic [31:0] Value;
  logic        Busy;
  logic        Done;
  logic        Valid;
  logic [23:0] EncData;

  modport master (
    output Start,
    output ImmSrc,
    output Value,
    input  Busy,
    input  Done,
    input  Valid,
    input  EncData
  );

  modport slave (
    input  Start,
    input  ImmSrc,
    input  Value,
    output Busy,
    output Done,
    output Valid,
    output EncData
  );
endinterface

// File: rtl/imm_encode.sv
// -----------------------------------------------------------------------------
// imm_encode
//   Inverse of the immediate extender. Given a 32-bit value and an immediate
//   class it produces the 24-bit instruction field that the extender would
//   expand back to the same value, or reports that no such field exists.
//
//   DP immediates (imm8 rotated right by 2*rot) are found by a sequential
//   search, one rotation per clock, lowest rotation first, so the result is
//   always the canonical (smallest rot) encoding. MEM and B immediates are a
//   single-cycle range/alignment check.
//
//   Ports
//     clk    in   rising-edge clock
//     reset  in   asynchronous, active-high reset
//     bus    imm_encode_if.slave
//              Start/ImmSrc/Value in; Busy/Done/Valid/EncData out
//
//   Timing, counted from the edge that samples Start (edge 0):
//     MEM / B / invalid class : Done after edge 1
//     DP matching at rot k    : Done after edge k+1
//     DP with no match        : Done after edge 16
//   Valid/EncData change only on the edge that raises Done; a new accepted
//   request leaves the previous result visible until its own completion.
// -----------------------------------------------------------------------------
module imm_encode (
  input  logic         clk,
  input  logic         reset,
  imm_encode_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_SEARCH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] SRC_DP  = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_B   = 2'b10;

  localparam logic [3:0] ROT_LAST = 4'd15;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Rotate left by sh bits. The upper half of a doubled word shifted left is
  // exactly the rotated value, including the sh == 0 case.
  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] sh);
    logic [63:0] dbl;
    dbl = {v, v} << sh;
    return dbl[63:32];
  endfunction

  // MEM offsets are a plain 12-bit unsigned field.
  function automatic logic mem_encodable(input logic [31:0] v);
    return (v[31:12] == 20'd0);
  endfunction

  // Branch offsets are word aligned and the top bits must be a sign
  // extension of bit 25 (the MSB of the 24-bit field after the <<2).
  function automatic logic b_encodable(input logic [31:0] v);
    return (v[1:0] == 2'b00) && (v[31:25] == {7{v[25]}});
  endfunction

  // A rotated candidate is a DP immediate when everything above imm8 is zero.
  function automatic logic dp_fits(input logic [31:0] t);
    return (t[31:8] == 24'd0);
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      state_q,  state_d;
  logic [3:0]  rot_q,    rot_d;
  logic [31:0] value_q,  value_d;
  logic [1:0]  src_q,    src_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;
  logic        valid_q,  valid_d;
  logic [23:0] enc_q,    enc_d;

  // Candidate for the rotation currently under test.
  logic [31:0] cand_s;
  // Start is only honoured while the encoder is not working.
  logic        accept_s;

  // Candidate rotation: value rotated left by 2*rot undoes the extender's
  // rotate-right, so a fit leaves imm8 in the low byte.
  always_comb begin
    cand_s = rol32(value_q, {rot_q, 1'b0});
  end

  // Request acceptance window: idle, or the single result cycle.
  always_comb begin
    accept_s = 1'b0;
    if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
      accept_s = bus.Start;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state, operand latch and result computation.
  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    value_d = value_q;
    src_d   = src_q;
    valid_d = valid_q;
    enc_d   = enc_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          value_d = bus.Value;
          src_d   = bus.ImmSrc;
          rot_d   = 4'd0;
          if (bus.ImmSrc == SRC_DP) begin
            state_d = S_SEARCH;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        state_d = S_DONE;
        case (src_q)
          SRC_MEM: begin
            valid_d = mem_encodable(value_q);
            enc_d   = mem_encodable(value_q) ? {12'd0, value_q[11:0]} : 24'd0;
          end
          SRC_B: begin
            valid_d = b_encodable(value_q);
            enc_d   = b_encodable(value_q) ? value_q[25:2] : 24'd0;
          end
          default: begin
            // Class 11 (and DP, which never reaches CALC) has no encoding.
            valid_d = 1'b0;
            enc_d   = 24'd0;
          end
        endcase
      end

      S_SEARCH: begin
        if (dp_fits(cand_s)) begin
          valid_d = 1'b1;
          enc_d   = {12'd0, rot_q, cand_s[7:0]};
          state_d = S_DONE;
        end else if (rot_q == ROT_LAST) begin
          // Search exhausted: rot stops at 15 and never wraps.
          valid_d = 1'b0;
          enc_d   = 24'd0;
          state_d = S_DONE;
        end else begin
          rot_d   = rot_q + 4'd1;
          state_d = S_SEARCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags follow the state being entered so they are registered
  // alongside it rather than decoded after the flops.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_CALC:   busy_d = 1'b1;
      S_SEARCH: busy_d = 1'b1;
      S_DONE:   done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // State, operand and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rot_q   <= 4'd0;
      value_q <= 32'd0;
      src_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      enc_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      value_q <= value_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      enc_q   <= enc_d;
    end
  end

  // Drive the interface straight from the output registers.
  always_comb begin
    bus.Busy    = busy_q;
    bus.Done    = done_q;
    bus.Valid   = valid_q;
    bus.EncData = enc_q;
  end

endmodule
